// File: rtl/register_universal_pkg.sv
// Package register_pkg: shared operation encodings for register_universal.
// Controllers driving the register import this package instead of using
// raw 3-bit literals.
package register_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage : register_pkg

// File: rtl/register_universal_if.sv
// register_universal_if: control/data bundle of the universal register.
//   sclr, en, mode, D, sin : driven by the controller (master)
//   Q, carry, zero         : driven by the register (slave)
interface register_universal_if #(parameter int WIDTH = 8);

    logic             sclr;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] D;
    logic             sin;
    logic [WIDTH-1:0] Q;
    logic             carry;
    logic             zero;

    modport master (
        output sclr, en, mode, D, sin,
        input  Q, carry, zero
    );

    modport slave (
        input  sclr, en, mode, D, sin,
        output Q, carry, zero
    );

endinterface : register_universal_if

// File: rtl/register_universal_next.sv
// register_universal_next: purely combinational next-state function.
//   q_i, carry_i : current register contents and flag
//   mode_i       : operation select (register_pkg MODE_*)
//   d_i, sin_i   : parallel load data, serial input
//   q_o, carry_o : contents and flag after the selected operation
module register_universal_next
    import register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             carry_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             carry_o
);

    always_comb begin
        q_o     = q_i;
        carry_o = carry_i;
        case (mode_i)
            MODE_HOLD: begin
                q_o     = q_i;
                carry_o = carry_i;
            end
            MODE_LOAD: begin
                q_o     = d_i;
                carry_o = 1'b0;
            end
            MODE_SHL: begin
                q_o     = {q_i[WIDTH-2:0], sin_i};
                carry_o = q_i[WIDTH-1];
            end
            MODE_SHR: begin
                q_o     = {sin_i, q_i[WIDTH-1:1]};
                carry_o = q_i[0];
            end
            MODE_ROL: begin
                q_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                carry_o = q_i[WIDTH-1];
            end
            MODE_ROR: begin
                q_o     = {q_i[0], q_i[WIDTH-1:1]};
                carry_o = q_i[0];
            end
            MODE_INC: begin
                // One extra bit so the wrap 2^W-1 -> 0 lands in the carry.
                {carry_o, q_o} = {1'b0, q_i} + {{WIDTH{1'b0}}, 1'b1};
            end
            MODE_DEC: begin
                q_o     = q_i - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_o = (q_i == '0);
            end
            default: begin
                q_o     = q_i;
                carry_o = carry_i;
            end
        endcase
    end

endmodule : register_universal_next

// File: rtl/register_universal.sv
// register_universal: parametrised storage register with load, shift,
// rotate, increment/decrement and carry/zero flags.
//   clk     : rising-edge clock
//   clear_n : asynchronous active-low reset (deassert synchronously to clk)
//   bus     : slave side of register_universal_if (sclr, en, mode, D, sin
//             in; Q, carry, zero out)
// Priority at each edge: sclr, then en, then mode.
module register_universal #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clear_n,
    register_universal_if.slave  bus
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_nxt;
    logic             carry_q;
    logic             carry_d;
    logic             carry_nxt;

    register_universal_next #(.WIDTH(WIDTH)) u_next (
        .q_i     (q_q),
        .carry_i (carry_q),
        .mode_i  (bus.mode),
        .d_i     (bus.D),
        .sin_i   (bus.sin),
        .q_o     (q_nxt),
        .carry_o (carry_nxt)
    );

    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (bus.sclr) begin
            q_d     = '0;
            carry_d = 1'b0;
        end else if (bus.en) begin
            q_d     = q_nxt;
            carry_d = carry_nxt;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.carry = carry_q;
    assign bus.zero  = (q_q == '0);

endmodule : register_universal

// File: tb/tb_register_universal.sv
module tb_register_universal;
    import register_pkg::*;

    logic clk;
    logic clear_n;

    register_universal_if #(.WIDTH(8)) bus ();

    register_universal #(.WIDTH(8)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Behavioural reference state (plain integer arithmetic, 8-bit).
    int m_q;
    int m_c;

    typedef struct {
        string      name;
        logic       sclr;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] eq, input logic ec);
        logic ez;
        ez = (eq == 8'h00);
        n_cmp++;
        if (bus.Q !== eq || bus.carry !== ec || bus.zero !== ez) begin
            n_fail++;
            $display("FAIL %s: got Q=%02h carry=%b zero=%b, want Q=%02h carry=%b zero=%b",
                     name, bus.Q, bus.carry, bus.zero, eq, ec, ez);
        end
    endtask

    // Caller is just after a rising edge; inputs are applied and the
    // following edge is taken, leaving the bench #1 after that edge.
    task automatic step(input logic sclr, input logic en, input logic [2:0] mode,
                        input logic [7:0] d, input logic sin);
        bus.sclr = sclr;
        bus.en   = en;
        bus.mode = mode;
        bus.D    = d;
        bus.sin  = sin;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic sclr, input logic en, input logic [2:0] mode,
                              input int d, input int sin);
        if (sclr) begin
            m_q = 0;
            m_c = 0;
        end else if (en) begin
            case (mode)
                3'd1: begin m_q = d; m_c = 0; end
                3'd2: begin m_c = m_q / 128; m_q = (m_q * 2 + sin) % 256; end
                3'd3: begin m_c = m_q % 2; m_q = m_q / 2 + sin * 128; end
                3'd4: begin m_c = m_q / 128; m_q = (m_q * 2) % 256 + m_c; end
                3'd5: begin m_c = m_q % 2; m_q = m_q / 2 + m_c * 128; end
                3'd6: begin m_c = (m_q == 255) ? 1 : 0; m_q = (m_q + 1) % 256; end
                3'd7: begin m_c = (m_q == 0) ? 1 : 0; m_q = (m_q + 255) % 256; end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [7:0] e;
        logic       ec;
        n_cmp   = 0;
        n_fail  = 0;
        clear_n = 1'b1;
        bus.sclr = 1'b0;
        bus.en   = 1'b0;
        bus.mode = MODE_HOLD;
        bus.D    = 8'h00;
        bus.sin  = 1'b0;

        // Power-on reset.
        #2 clear_n = 1'b0;
        #1 check("reset_initial", 8'h00, 1'b0);
        @(posedge clk);
        #1 clear_n = 1'b1;

        // Asynchronous reset between edges.
        step(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0);
        check("reset_preload", 8'h3C, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0);
        check("reset_preshift", 8'hF0, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0);
        check("reset_carry_set", 8'hE0, 1'b1);
        bus.mode = MODE_INC;
        #3 clear_n = 1'b0;
        #1 check("reset_async", 8'h00, 1'b0);
        @(posedge clk);
        #1 check("reset_held_over_edge", 8'h00, 1'b0);
        clear_n = 1'b1;
        step(1'b0, 1'b0, MODE_INC, 8'h00, 1'b0);
        step(1'b0, 1'b0, MODE_INC, 8'h00, 1'b0);
        check("reset_release_en0", 8'h00, 1'b0);

        // Table of single-edge operations (applied in order).
        vecs.push_back('{"load_a5",     1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0});
        vecs.push_back('{"shl_sin1",    1'b0, 1'b1, MODE_SHL,  8'hFF, 1'b1, 8'h4B, 1'b1});
        vecs.push_back('{"reload_a5",   1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b1, 8'hA5, 1'b0});
        vecs.push_back('{"shr_sin0",    1'b0, 1'b1, MODE_SHR,  8'h00, 1'b0, 8'h52, 1'b1});
        vecs.push_back('{"load_81",     1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 8'h81, 1'b0});
        vecs.push_back('{"rol_81",      1'b0, 1'b1, MODE_ROL,  8'h00, 1'b0, 8'h03, 1'b1});
        vecs.push_back('{"reload_81",   1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 8'h81, 1'b0});
        vecs.push_back('{"ror_81",      1'b0, 1'b1, MODE_ROR,  8'h00, 1'b0, 8'hC0, 1'b1});
        vecs.push_back('{"load_ff",     1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{"inc_wrap",    1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"inc_after",   1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{"dec_to_0",    1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"dec_wrap",    1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{"hold_mode",   1'b0, 1'b1, MODE_HOLD, 8'h12, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{"en0_hold",    1'b0, 1'b0, MODE_LOAD, 8'h34, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{"load_80",     1'b0, 1'b1, MODE_LOAD, 8'h80, 1'b0, 8'h80, 1'b0});
        vecs.push_back('{"shl_out1_z",  1'b0, 1'b1, MODE_SHL,  8'hFF, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"load_55",     1'b0, 1'b1, MODE_LOAD, 8'h55, 1'b0, 8'h55, 1'b0});
        vecs.push_back('{"sclr_wins",   1'b1, 1'b1, MODE_LOAD, 8'hAA, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"en0_inc_1",   1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"en0_inc_2",   1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"en0_inc_3",   1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"load_01",     1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{"shr_out1_in1",1'b0, 1'b1, MODE_SHR,  8'h00, 1'b1, 8'h80, 1'b1});
        vecs.push_back('{"sclr_en0",    1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sclr, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
            check(vecs[i].name, vecs[i].exp_q, vecs[i].exp_c);
        end

        // Eight rotates return to the start value.
        step(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0);
        e = 8'h81;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0);
            ec = e[7];
            e  = {e[6:0], e[7]};
            check($sformatf("rol_seq_%0d", i), e, ec);
        end
        check("rol_seq_back", 8'h81, 1'b1);

        // Count sequence with two disabled cycles.
        step(1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0);
        check("count_load", 8'h00, 1'b0);
        e = 8'h00;
        for (int i = 0; i < 13; i++) begin
            logic en_now;
            en_now = !(i == 5 || i == 6);
            step(1'b0, en_now, MODE_INC, 8'h00, 1'b0);
            if (en_now) e = e + 8'h01;
            check($sformatf("count_%0d", i), e, 1'b0);
        end
        check("count_end", 8'h0B, 1'b0);

        // Randomised run against the reference model.
        step(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0);
        m_q = 0;
        m_c = 0;
        for (int i = 0; i < 400; i++) begin
            logic       r_sclr;
            logic       r_en;
            logic [2:0] r_mode;
            int         r_d;
            int         r_sin;
            if ($urandom_range(0, 49) == 0) begin
                #3 clear_n = 1'b0;
                m_q = 0;
                m_c = 0;
                #1 check("rand_async_reset", 8'(m_q), m_c[0]);
                @(posedge clk);
                #1 clear_n = 1'b1;
            end
            r_sclr = ($urandom_range(0, 15) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_mode = 3'($urandom_range(0, 7));
            r_d    = int'($urandom_range(0, 255));
            r_sin  = int'($urandom_range(0, 1));
            step(r_sclr, r_en, r_mode, 8'(r_d), r_sin[0]);
            model_step(r_sclr, r_en, r_mode, r_d, r_sin);
            check($sformatf("rand_%0d_m%0d", i, r_mode), 8'(m_q), m_c[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_register_universal

// File: doc/register_universal.md
# register_universal

Parametrised universal register: the next generation of the team's plain 8-bit clocked register. It adds configurable width, enable, synchronous clear, shift and rotate with serial input, increment and decrement, and carry and zero flags. It is a general datapath storage element for counters, serialisers and accumulator-style stages, with one-cycle update latency.

## Interface
- WIDTH, 8, data width in bits (≥2)
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- sclr  input  1  synchronous clear
- en  input  1  operation enable
- mode  input  3  operation select (see Operation)
- D  input  WIDTH  parallel load data
- sin  input  1  serial input for shifts
- Q  output  WIDTH  register contents
- carry  output  1  registered carry/borrow/shift-out flag
- zero  output  1  combinational, high when Q == 0

## Operation
- Reset: clear_n low immediately forces Q=0 and carry=0, with no clock edge needed. zero=1 while in reset.
- Priority at each rising edge, highest first:
  - sclr=1: Q=0, carry=0.
  - en=0: Q and carry hold.
  - Otherwise, mode selects the operation below.
- Modes:
  - 000 HOLD: Q and carry unchanged.
  - 001 LOAD: Q=D, carry=0.
  - 010 SHL: Q={Q[W-2:0],sin}, carry=Q[W-1].
  - 011 SHR: Q={sin,Q[W-1:1]}, carry=Q[0].
  - 100 ROL: Q={Q[W-2:0],Q[W-1]}, carry=Q[W-1].
  - 101 ROR: Q={Q[0],Q[W-1:1]}, carry=Q[0].
  - 110 INC: {carry,Q}=Q+1, computed WIDTH+1 bits wide. carry=1 only on wrap 2^W-1→0.
  - 111 DEC: Q=Q-1 modulo 2^W. carry=1 (borrow) only on wrap 0→2^W-1.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is never saturated.
- Shift and rotate flags always reflect the bit shifted out, even if it equals the incoming bit.
- The sin and D inputs are ignored in modes that do not use them.

## Timing
- All state changes occur on the rising edge of clk, except reset.
- Latency is one cycle: inputs sampled at edge N appear on Q and carry after edge N.
- zero is combinational from Q and is valid in the same cycle as Q.
- Reset mid-operation aborts the operation. The first edge after clear_n rises operates on Q=0.
- clear_n must be deasserted synchronously to clk by the system. The block contains no reset synchroniser.
- sclr together with any en or mode value: the clear wins.
- No illegal mode values exist, since all 8 encodings are defined.

## Structure
- Shared package register_pkg holds the mode encoding constants MODE_HOLD through MODE_DEC (3-bit) for reuse by controllers.
- One combinational sub-module, register_universal_next, computes next Q and next carry from Q, mode, D and sin.
- The top level contains only the priority logic and the flops.

## Test plan
- Reset: load 0x3C, then pull clear_n low between edges. Q=0x00, carry=0 and zero=1 immediately. After release with en=0, Q stays 0x00.
- Shifts: LOAD 0xA5. SHL with sin=1 gives Q=0x4B, carry=1. Reload 0xA5. SHR with sin=0 gives Q=0x52, carry=1.
- Rotates: LOAD 0x81. ROL gives Q=0x03, carry=1. Reload 0x81. ROR gives Q=0xC0, carry=1. Eight successive ROLs from 0x81 return Q=0x81.
- Wrap: LOAD 0xFF then INC gives Q=0x00, carry=1, zero=1. A further INC gives Q=0x01, carry=0. DEC twice then gives Q=0xFF, carry=1.
- Priority: with Q=0x55, set sclr=1, en=1, mode=LOAD, D=0xAA. Result is Q=0x00, carry=0. Then en=0, mode=INC for 3 cycles: Q stays 0x00.
- Count sequence: LOAD 0x00, then INC 11 cycles with en toggled off for 2 cycles mid-run. Q steps 0x01…0x0B, holds during the disabled cycles, and ends at 0x0B.
